decode_stage: RTL and testbench

- Parametrised decode/operand-fetch pipeline stage between fetch and the ALU.
- Decodes one 32-bit instruction per handshake and drives two combinational register-file read selects.
- Applies write-back forwarding and register-0 zeroing, and selects an immediate for RRI forms.
- Registers operands, control word and destination into a single output slot with valid/ready flow control, flush and an illegal-instruction flag.

---
 rtl/decode_stage_pkg.sv | 66 ++++++
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage_instr_decoder.sv | 69 ++++++
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: instruction kinds, opcodes, the ALU
// control word and the decoded-instruction record.
package decode_pkg;

  localparam logic [6:0] OPC_RRR = 7'h33;
  localparam logic [6:0] OPC_RRI = 7'h13;

  typedef enum logic [1:0] {
    KIND_RRR     = 2'd0,
    KIND_RRI     = 2'd1,
    KIND_ILLEGAL = 2'd2
  } kind_e;

  typedef enum logic [2:0] {
    CORE_OP_ADD   = 3'd0,
    CORE_OP_AND   = 3'd1,
    CORE_OP_OR    = 3'd2,
    CORE_OP_XOR   = 3'd3,
    CORE_OP_SLT   = 3'd4,
    CORE_OP_SLTU  = 3'd5,
    CORE_OP_SHIFT = 3'd6
  } core_op_e;

  typedef enum logic [1:0] {
    UNARY_OP_ID  = 2'd0,
    UNARY_OP_NEG = 2'd1,
    UNARY_OP_NOT = 2'd2
  } unary_op_e;

  typedef enum logic [1:0] {
    SHIFT_SHL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2
  } shift_e;

  typedef struct packed {
    shift_e dir;
    logic   en;
  } s_shift;

  typedef struct packed {
    core_op_e  core_op;
    unary_op_e op_a;
    unary_op_e op_b;
    s_shift    shift;
    unary_op_e op_out;
  } s_control;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rs;
    logic [4:0]  rq;
    logic [4:0]  rd;
    logic [11:0] imm;
    s_control    alu_config;
  } s_decoded;

  localparam s_control CTRL_NOP = '{
    core_op: CORE_OP_ADD,
    op_a:    UNARY_OP_ID,
    op_b:    UNARY_OP_ID,
    shift:   '{dir: SHIFT_SHL, en: 1'b0},
    op_out:  UNARY_OP_ID
  };

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle of the decode stage: fetch handshake, register-file read ports,
// write-back snoop and the registered output slot towards the ALU.
interface decode_stage_if
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [REG_W-1:0] reg_a_sel;
  logic [XLEN-1:0]  reg_a;
  logic [REG_W-1:0] reg_b_sel;
  logic [XLEN-1:0]  reg_b;
  logic             wb_en;
  logic [REG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  s_control         control;
  logic [REG_W-1:0] rd;
  logic             illegal;
  logic             busy;

  // environment side: fetch, register file, write-back and ALU
  modport master (
    output in_valid, instruction, reg_a, reg_b, wb_en, wb_rd, wb_data, flush, out_ready,
    input  in_ready, reg_a_sel, reg_b_sel, out_valid, a, b, control, rd, illegal, busy
  );

  modport slave (
    input  in_valid, instruction, reg_a, reg_b, wb_en, wb_rd, wb_data, flush, out_ready,
    output in_ready, reg_a_sel, reg_b_sel, out_valid, a, b, control, rd, illegal, busy
  );
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Purely combinational field extraction and ALU control generation for one
// 32-bit instruction word.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0] i_instruction,
  output s_decoded    o_decoded
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_alt;
  kind_e      w_kind;
  s_control   w_ctrl;

  assign w_opcode = i_instruction[6:0];
  assign w_funct3 = i_instruction[14:12];
  assign w_alt    = i_instruction[30];

  // opcode -> instruction kind
  always_comb begin
    w_kind = KIND_ILLEGAL;
    case (w_opcode)
      OPC_RRR: w_kind = KIND_RRR;
      OPC_RRI: w_kind = KIND_RRI;
      default: w_kind = KIND_ILLEGAL;
    endcase
  end

  // funct3/funct7 -> control word; subtract only exists in register form
  always_comb begin
    w_ctrl = CTRL_NOP;
    case (w_funct3)
      3'b000: begin
        if (w_kind == KIND_RRR && w_alt) begin
          w_ctrl.op_b = UNARY_OP_NEG;
        end else begin
          w_ctrl.op_b = UNARY_OP_ID;
        end
      end
      3'b001: begin
        w_ctrl.core_op = CORE_OP_SHIFT;
        w_ctrl.shift   = '{dir: SHIFT_SHL, en: 1'b1};
      end
      3'b010: w_ctrl.core_op = CORE_OP_SLT;
      3'b011: w_ctrl.core_op = CORE_OP_SLTU;
      3'b100: w_ctrl.core_op = CORE_OP_XOR;
      3'b101: begin
        w_ctrl.core_op = CORE_OP_SHIFT;
        if (w_alt) begin
          w_ctrl.shift = '{dir: SHIFT_SRA, en: 1'b1};
        end else begin
          w_ctrl.shift = '{dir: SHIFT_SRL, en: 1'b1};
        end
      end
      3'b110: w_ctrl.core_op = CORE_OP_OR;
      3'b111: w_ctrl.core_op = CORE_OP_AND;
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  assign o_decoded.kind       = w_kind;
  assign o_decoded.rs         = i_instruction[19:15];
  assign o_decoded.rq         = i_instruction[24:20];
  assign o_decoded.rd         = i_instruction[11:7];
  assign o_decoded.imm        = i_instruction[31:20];
  assign o_decoded.alu_config = (w_kind == KIND_ILLEGAL) ? CTRL_NOP : w_ctrl;

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: forwards write-back data, selects the immediate
// and holds the result in a single valid/ready output slot.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int REG_W = $clog2(NREG),
  parameter int IMM_W = 12
) (
  input logic           clk,
  input logic           nrst,
  decode_stage_if.slave bus
);

  // register 0 reads as zero and is never a forwarding target
  function automatic logic [XLEN-1:0] f_operand(
    input logic [REG_W-1:0] sel,
    input logic             wb_en,
    input logic [REG_W-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_data,
    input logic [XLEN-1:0]  rf_data
  );
    if (sel == '0) begin
      return '0;
    end else if (wb_en && (wb_rd == sel)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

  s_decoded         w_dec;
  logic [REG_W-1:0] w_sel_a;
  logic [REG_W-1:0] w_sel_b;
  logic [XLEN-1:0]  w_opa;
  logic [XLEN-1:0]  w_opb;
  logic [XLEN-1:0]  w_imm;
  logic             w_capture;

  logic [XLEN-1:0]  w_nxt_a;
  logic [XLEN-1:0]  w_nxt_b;
  s_control         w_nxt_ctrl;
  logic [REG_W-1:0] w_nxt_rd;
  logic             w_nxt_ill;

  logic             r_valid;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  s_control         r_ctrl;
  logic [REG_W-1:0] r_rd;
  logic             r_ill;

  instr_decoder u_instr_decoder (
    .i_instruction (bus.instruction),
    .o_decoded     (w_dec)
  );

  assign w_sel_a       = w_dec.rs[REG_W-1:0];
  assign w_sel_b       = w_dec.rq[REG_W-1:0];
  assign bus.reg_a_sel = w_sel_a;
  assign bus.reg_b_sel = w_sel_b;

  assign w_opa = f_operand(w_sel_a, bus.wb_en, bus.wb_rd, bus.wb_data, bus.reg_a);
  assign w_opb = f_operand(w_sel_b, bus.wb_en, bus.wb_rd, bus.wb_data, bus.reg_b);
  assign w_imm = {{(XLEN-IMM_W){w_dec.imm[IMM_W-1]}}, w_dec.imm[IMM_W-1:0]};

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_capture    = bus.in_valid && bus.in_ready && !bus.flush;

  // slot contents for the instruction presented this cycle
  always_comb begin
    w_nxt_a    = '0;
    w_nxt_b    = '0;
    w_nxt_ctrl = CTRL_NOP;
    w_nxt_rd   = '0;
    w_nxt_ill  = 1'b0;
    case (w_dec.kind)
      KIND_RRR: begin
        w_nxt_a    = w_opa;
        w_nxt_b    = w_opb;
        w_nxt_ctrl = w_dec.alu_config;
        w_nxt_rd   = w_dec.rd[REG_W-1:0];
      end
      KIND_RRI: begin
        w_nxt_a    = w_opa;
        w_nxt_b    = w_imm;
        w_nxt_ctrl = w_dec.alu_config;
        w_nxt_rd   = w_dec.rd[REG_W-1:0];
      end
      default: begin
        w_nxt_ill = 1'b1;
      end
    endcase
  end

  // output slot: reset > flush > capture (also replaces a draining entry) > drain > hold
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= CTRL_NOP;
      r_rd    <= '0;
      r_ill   <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_a     <= w_nxt_a;
      r_b     <= w_nxt_b;
      r_ctrl  <= w_nxt_ctrl;
      r_rd    <= w_nxt_rd;
      r_ill   <= w_nxt_ill;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.control   = r_ctrl;
  assign bus.rd        = r_rd;
  assign bus.illegal   = r_ill;
  assign bus.busy      = r_valid && !bus.out_ready;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage with a few directed scenarios
// (reset, forwarding, backpressure, illegal opcode, flush) up front.
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    s_control    ctrl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .REG_W(5)) ifc ();

  decode_stage dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc.slave)
  );

  logic [31:0] rf [32];
  assign ifc.reg_a = rf[ifc.reg_a_sel];
  assign ifc.reg_b = rf[ifc.reg_b_sel];

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // operation table: what each funct3 means to the ALU
  function automatic s_control ref_ctrl(input logic is_reg, input logic [2:0] f3, input logic alt);
    s_control c;
    c = CTRL_NOP;
    if (f3 == 3'd0 && is_reg && alt) c.op_b = UNARY_OP_NEG;
    if (f3 == 3'd2) c.core_op = CORE_OP_SLT;
    if (f3 == 3'd3) c.core_op = CORE_OP_SLTU;
    if (f3 == 3'd4) c.core_op = CORE_OP_XOR;
    if (f3 == 3'd6) c.core_op = CORE_OP_OR;
    if (f3 == 3'd7) c.core_op = CORE_OP_AND;
    if (f3 == 3'd1 || f3 == 3'd5) begin
      c.core_op  = CORE_OP_SHIFT;
      c.shift.en = 1'b1;
      c.shift.dir = (f3 == 3'd1) ? SHIFT_SHL : (alt ? SHIFT_SRA : SHIFT_SRL);
    end
    return c;
  endfunction

  function automatic logic [31:0] ref_operand(input int idx, input logic we, input int wrd, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wrd == idx) return wd;
    return rf[idx];
  endfunction

  function automatic exp_t ref_model(input logic [31:0] ins, input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    exp_t e;
    int   rs, rq, imm;
    rs  = int'(ins[19:15]);
    rq  = int'(ins[24:20]);
    imm = int'(ins[31:20]);
    if (imm >= 2048) imm = imm - 4096;
    e = '{a: 32'd0, b: 32'd0, ctrl: CTRL_NOP, rd: 5'd0, ill: 1'b1};
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      e.ill  = 1'b0;
      e.rd   = ins[11:7];
      e.a    = ref_operand(rs, we, int'(wrd), wd);
      e.b    = (ins[6:0] == 7'h13) ? 32'(imm) : ref_operand(rq, we, int'(wrd), wd);
      e.ctrl = ref_ctrl(ins[6:0] == 7'h33, ins[14:12], ins[30]);
    end
    return e;
  endfunction

  // one clock of stimulus; the expected slot is queued if the stage accepts
  task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic ordy,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    ifc.in_valid    = v;
    ifc.instruction = ins;
    ifc.flush       = fl;
    ifc.out_ready   = ordy;
    ifc.wb_en       = we;
    ifc.wb_rd       = wrd;
    ifc.wb_data     = wd;
    @(negedge clk);
    if (nrst && v && ifc.in_ready && !fl) sb_q.push_back(ref_model(ins, we, wrd, wd));
    @(posedge clk);
    #1;
  endtask

  // monitor: handshake flags every cycle, hold stability, and slot contents on transfer
  logic hold_chk = 1'b0;
  exp_t snap;
  always @(negedge clk) begin
    exp_t e, got;
    got = '{a: ifc.a, b: ifc.b, ctrl: ifc.control, rd: ifc.rd, ill: ifc.illegal};
    if (!nrst) begin
      sb_q.delete();
      hold_chk = 1'b0;
    end else begin
      chk("in_ready", 64'(ifc.in_ready), 64'(!ifc.out_valid || ifc.out_ready));
      chk("busy", 64'(ifc.busy), 64'(ifc.out_valid && !ifc.out_ready));
      if (hold_chk) begin
        chk("hold_valid", 64'(ifc.out_valid), 64'd1);
        chk("hold_slot", 64'(got), 64'(snap));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("out_a", 64'(got.a), 64'(e.a));
          chk("out_b", 64'(got.b), 64'(e.b));
          chk("out_ctrl", 64'(got.ctrl), 64'(e.ctrl));
          chk("out_rd", 64'(got.rd), 64'(e.rd));
          chk("out_illegal", 64'(got.ill), 64'(e.ill));
        end
      end else if (ifc.out_valid && ifc.flush && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      hold_chk = ifc.out_valid && !ifc.out_ready && !ifc.flush;
      snap     = got;
    end
  end

  localparam logic [31:0] I_RRR  = 32'h002081B3;
  localparam logic [31:0] I_RRI  = 32'hFFF08293;
  localparam logic [31:0] I_ZERO = 32'h002001B3;
  localparam logic [31:0] I_ILL  = 32'h1234567F;

  initial begin
    logic [31:0] ins;
    logic [4:0]  wrd;
    int          pick;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    nrst = 1'b0;
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    nrst = 1'b1;
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_slot", 64'({ifc.a, ifc.b, ifc.control, ifc.rd, ifc.illegal}),
        64'({32'd0, 32'd0, CTRL_NOP, 5'd0, 1'b0}));

    // RRR then held while the next instruction waits
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    ifc.instruction = I_RRR;
    #1;
    chk("sel_a", 64'(ifc.reg_a_sel), 64'd1);
    chk("sel_b", 64'(ifc.reg_b_sel), 64'd2);
    cyc(1'b1, I_RRR, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("rrr_valid", 64'(ifc.out_valid), 64'd1);
    chk("rrr_slot", 64'({ifc.a, ifc.b, ifc.rd}), 64'({32'd5, 32'd7, 5'd3}));
    chk("rrr_ctrl", 64'(ifc.control), 64'(CTRL_NOP));
    rf[1] = 32'd10;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, I_RRI, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("bp_busy", 64'(ifc.busy), 64'd1);
      chk("bp_a", 64'(ifc.a), 64'd5);
    end
    cyc(1'b1, I_RRI, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("rri_valid", 64'(ifc.out_valid), 64'd1);
    chk("rri_slot", 64'({ifc.a, ifc.b, ifc.rd, ifc.illegal}), 64'({32'd10, 32'hFFFFFFFF, 5'd5, 1'b0}));

    // forwarding and register-0 zeroing
    cyc(1'b1, I_RRR, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000DEAD);
    chk("fwd_b", 64'(ifc.b), 64'h0000DEAD);
    rf[0] = 32'h55;
    cyc(1'b1, I_ZERO, 1'b0, 1'b1, 1'b1, 5'd0, 32'h1234);
    chk("zero_a", 64'(ifc.a), 64'd0);

    // illegal opcode, then flush drops it and the incoming instruction
    cyc(1'b1, I_ILL, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("ill_flag", 64'(ifc.illegal), 64'd1);
    chk("ill_slot", 64'({ifc.a, ifc.b, ifc.control, ifc.rd}), 64'({32'd0, 32'd0, CTRL_NOP, 5'd0}));
    cyc(1'b1, I_RRR, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("flush_valid", 64'(ifc.out_valid), 64'd0);

    // reset mid-stream with a held entry
    cyc(1'b1, I_RRR, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    nrst = 1'b0;
    cyc(1'b1, I_RRI, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("mrst_valid", 64'(ifc.out_valid), 64'd0);
    chk("mrst_slot", 64'({ifc.a, ifc.b, ifc.control, ifc.rd, ifc.illegal}),
        64'({32'd0, 32'd0, CTRL_NOP, 5'd0, 1'b0}));
    chk("mrst_in_ready", 64'(ifc.in_ready), 64'd1);
    cyc(1'b1, I_RRI, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("mrst_no_capture", 64'(ifc.out_valid), 64'd0);
    nrst = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("mrst_after", 64'(ifc.out_valid), 64'd0);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      ins  = $urandom;
      pick = $urandom_range(0, 4);
      if (pick < 3) ins[6:0] = 7'h33;
      else if (pick == 3) ins[6:0] = 7'h13;
      wrd = $urandom_range(0, 1) ? ins[19:15] : ($urandom_range(0, 1) ? ins[24:20] : 5'($urandom));
      cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), wrd, $urandom);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
